uart_cmd_receiver: RTL and testbench
====================================

// Module: uart_cmd_receiver
// PURPOSE
//  Serial receive side of the host/Arduino link: 8N1 UART receiver plus command decoder.
//  Turns bytes arriving on rx_serial into single-cycle command strobes for the capture path.
//  cmd_image requests a frame dump over the image UART; cmd_color requests the current color code.
//  Sits beside the image/color transmitters and runs on the same system clk.
// PARAMETERS
//  CLK_HZ     25_000_000  system clock frequency in Hz
//  BAUD       115_200     line rate in bit/s; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, 217 at defaults)
//  CMD_IMAGE  8'h49       byte ('I') that fires cmd_image
//  CMD_COLOR  8'h43       byte ('C') that fires cmd_color
// PORTS
//  clk        in   1  system clock; every flop is on its rising edge
//  reset      in   1  asynchronous, active-low reset
//  rx_serial  in   1  asynchronous UART line; idles high
//  rx_data    out  8  last correctly framed byte; holds its value until the next good byte
//  rx_valid   out  1  1-cycle pulse when rx_data updates
//  cmd_image  out  1  1-cycle pulse, same cycle as rx_valid, when the byte equals CMD_IMAGE
//  cmd_color  out  1  1-cycle pulse, same cycle as rx_valid, when the byte equals CMD_COLOR
//  frame_err  out  1  1-cycle pulse when the stop bit samples low (or parity fails, see CONFIG)
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset values: rx_data=0, all pulses=0, busy=0, state=IDLE, counters=0, synchronizer=2'b11.
//  - rx_serial passes through a 2-FF synchronizer; "rx" below means the synchronized value.
//  - bit_cnt counts 0..CLKS_PER_BIT-1; idx counts data bits 0..7.
//  - IDLE:  a 1->0 transition on rx starts a frame -> START with bit_cnt=0.
//  - START: wait until bit_cnt=CLKS_PER_BIT/2-1, then sample rx.
//           rx=0 -> DATA with bit_cnt=0. rx=1 -> glitch -> IDLE, no output.
//  - DATA:  sample each time bit_cnt=CLKS_PER_BIT-1; shift in LSB first.
//           After idx=7 -> STOP (or PARITY when enabled).
//  - STOP:  sample at bit_cnt=CLKS_PER_BIT-1.
//           rx=1 -> DONE. rx=0 -> frame_err pulse -> WAIT_IDLE.
//  - DONE (1 cycle): load rx_data, pulse rx_valid plus the matching cmd_*, -> IDLE.
//      Latency: rx_valid rises 1 cycle after the stop-bit sample (about 9.5 bit times after the start edge).
//  - WAIT_IDLE: stay until rx=1 (covers a line break), then -> IDLE. rx_data is not updated.
//  - cmd_image and cmd_color are mutually exclusive. A byte matching neither gives rx_valid only.
//  - A falling edge while busy is ignored; only IDLE detects a start.
//  - Back-to-back frames: a start edge arriving in the first cycle after DONE is detected.
//  - reset asserted mid-frame: immediate return to IDLE with all outputs at reset values.
//    The partial byte is discarded.
//  - All arithmetic is unsigned. bit_cnt is $clog2(CLKS_PER_BIT) bits wide and never wraps past CLKS_PER_BIT-1.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - Frame is 8E1. After DATA, a PARITY state samples the 9th bit at bit_cnt=CLKS_PER_BIT-1.
//   - If (^data ^ parity_bit) != 0, the frame is flagged bad.
//   - A bad frame pulses frame_err after the stop sample, then goes to WAIT_IDLE with no rx_valid and no cmd_*.
//  Not defined: 8N1 only; no PARITY state; the 9th bit time is the stop bit.
// TESTING
//  1 Send 0x49 at 115200 (217 clk/bit) -> exactly one rx_valid; rx_data=0x49; cmd_image=1 in that same cycle; cmd_color=0.
//  2 Send 0x43 immediately followed by 0x55 -> cmd_color with rx_data=0x43, then rx_valid only with rx_data=0x55; no frame_err.
//  3 Drive rx low for 50 clks, then high -> back in IDLE, busy low; no rx_valid and no frame_err.
//  4 Send 0xA5 with stop bit forced low, then 0x0F normally -> frame_err pulse, rx_data stays 0x00; then rx_valid with 0x0F.
//  5 Assert reset for 3 clks during data bit 4, then send 0x49 -> all outputs 0 while in reset; 0x49 then decodes per test 1.
//  6 With UART_RX_PARITY_EN defined: 0x49 with correct even parity -> cmd_image. Same byte with parity flipped -> frame_err, no rx_valid.

Source files
------------

// File: rtl/uart_cmd_receiver.sv
// 8N1 UART receiver with single-byte command decode for the host link.
// Build with UART_RX_PARITY_EN defined to receive 8E1 frames and drop bad-parity bytes.
module uart_cmd_receiver #(
  parameter int         CLK_HZ    = 25_000_000,
  parameter int         BAUD      = 115_200,
  parameter logic [7:0] CMD_IMAGE = 8'h49,
  parameter logic [7:0] CMD_COLOR = 8'h43
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       cmd_image,
  output logic       cmd_color,
  output logic       frame_err,
  output logic       busy
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE} state_t;

  state_t        state;
  logic [1:0]    rx_sync;
  logic          rx, rx_prev;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          stop_ok;

  assign rx   = rx_sync[1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_serial};
      rx_prev <= rx;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign stop_ok = rx & ~par_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       par_bad <= 1'b0;
    else if (state == PARITY && bit_cnt == BIT_LAST) par_bad <= ^shift ^ rx;
  end
`else
  assign stop_ok = rx;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      cmd_image <= 1'b0;
      cmd_color <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      cmd_image <= 1'b0;
      cmd_color <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          idx     <= '0;
          if (rx_prev && !rx) state <= START;
        end
        // Mid-start-bit re-check rejects line glitches shorter than half a bit.
        START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            state   <= rx ? IDLE : DATA;
          end else begin
            bit_cnt <= CW'(bit_cnt + 1'b1);
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            shift   <= {rx, shift[7:1]};
            idx     <= 3'(idx + 1'b1);
`ifdef UART_RX_PARITY_EN
            if (idx == 3'd7) state <= PARITY;
`else
            if (idx == 3'd7) state <= STOP;
`endif
          end else begin
            bit_cnt <= CW'(bit_cnt + 1'b1);
          end
        end
        PARITY: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            state   <= STOP;
          end else begin
            bit_cnt <= CW'(bit_cnt + 1'b1);
          end
        end
        // Strobes are set here so they are visible during the DONE cycle.
        STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (stop_ok) begin
              rx_data   <= shift;
              rx_valid  <= 1'b1;
              cmd_image <= (shift == CMD_IMAGE);
              cmd_color <= (shift == CMD_COLOR);
              state     <= DONE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            bit_cnt <= CW'(bit_cnt + 1'b1);
          end
        end
        DONE:      state <= IDLE;
        WAIT_IDLE: if (rx) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Directed + randomized bench for uart_cmd_receiver against a byte-level frame model.
module tb_uart_cmd_receiver;
  localparam int CPB = 25_000_000 / 115_200;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Valid should appear about (NBITS-0.5) bit times after the start edge.
  localparam int LAT_NOM = (NBITS * CPB) - CPB / 2;

  logic       clk = 1'b0, reset = 1'b0, rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, cmd_image, cmd_color, frame_err, busy;

  uart_cmd_receiver dut (
    .clk(clk), .reset(reset), .rx_serial(rx_serial), .rx_data(rx_data),
    .rx_valid(rx_valid), .cmd_image(cmd_image), .cmd_color(cmd_color),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0, cyc = 0;
  int n_valid = 0, n_img = 0, n_col = 0, n_ferr = 0, n_stray = 0, valid_cyc = 0;
  logic [7:0] last_v = '0;
  logic       last_img = 1'b0, last_col = 1'b0;
  logic [7:0] m_data = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_v    = rx_data;
      last_img  = cmd_image;
      last_col  = cmd_color;
      valid_cyc = cyc;
    end
    if (cmd_image) n_img++;
    if (cmd_color) n_col++;
    if (frame_err) n_ferr++;
    if (((cmd_image || cmd_color) && !rx_valid) || (cmd_image && cmd_color)) n_stray++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold_bit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  int start_cyc;
  task automatic send(input logic [7:0] b, input bit stop_val, input bit par_flip);
    @(posedge clk); #1;
    start_cyc = cyc;
    rx_serial = 1'b0; hold_bit();
    for (int i = 0; i < 8; i++) begin rx_serial = b[i]; hold_bit(); end
`ifdef UART_RX_PARITY_EN
    rx_serial = (^b) ^ par_flip; hold_bit();
`endif
    rx_serial = stop_val; hold_bit();
    rx_serial = 1'b1;
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] b, input bit stop_ok,
                                input bit par_flip);
    int v0, i0, c0, f0, s0, lat;
    bit good;
    v0 = n_valid; i0 = n_img; c0 = n_col; f0 = n_ferr; s0 = n_stray;
    send(b, stop_ok, par_flip);
    good = stop_ok;
`ifdef UART_RX_PARITY_EN
    good = good && !par_flip;
`endif
    if (good) m_data = b;
    chk({tag, "_valid_cnt"}, n_valid - v0, good ? 1 : 0);
    chk({tag, "_ferr_cnt"},  n_ferr - f0,  good ? 0 : 1);
    chk({tag, "_img_cnt"},   n_img - i0,   (good && b == 8'h49) ? 1 : 0);
    chk({tag, "_col_cnt"},   n_col - c0,   (good && b == 8'h43) ? 1 : 0);
    chk({tag, "_stray"},     n_stray - s0, 0);
    chk({tag, "_rx_data"},   rx_data,      m_data);
    if (good) begin
      lat = valid_cyc - start_cyc;
      chk({tag, "_byte"},    last_v,  b);
      chk({tag, "_img_bit"}, last_img, b == 8'h49);
      chk({tag, "_col_bit"}, last_col, b == 8'h43);
      chk({tag, "_latency"}, (lat >= LAT_NOM - 10 && lat <= LAT_NOM + 10), 1);
    end
  endtask

  initial begin
    int v0, f0;
    logic [7:0] rb;
    bit rstop;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {rx_data, rx_valid, cmd_image, cmd_color, frame_err, busy}, '0);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Bad stop first so rx_data must still read 0, then a clean byte.
    send_and_check("bad_stop_a5", 8'hA5, 1'b0, 1'b0);
    repeat (5) @(posedge clk); @(negedge clk);
    chk("bad_stop_busy", busy, 1'b0);
    send_and_check("after_err_0f", 8'h0F, 1'b1, 1'b0);

    send_and_check("img_49", 8'h49, 1'b1, 1'b0);

    // Back-to-back: no idle gap between stop and next start.
    send_and_check("b2b_43", 8'h43, 1'b1, 1'b0);
    send_and_check("b2b_55", 8'h55, 1'b1, 1'b0);

    // Short low pulse is a glitch, not a frame.
    v0 = n_valid; f0 = n_ferr;
    @(posedge clk); #1 rx_serial = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_hi", busy, 1'b1);
    repeat (30) @(posedge clk); #1 rx_serial = 1'b1;
    repeat (CPB) @(posedge clk); @(negedge clk);
    chk("glitch_busy_lo", busy, 1'b0);
    chk("glitch_no_valid", n_valid - v0, 0);
    chk("glitch_no_ferr",  n_ferr - f0, 0);

    // Reset in the middle of data bit 4 of 0x49.
    @(posedge clk); #1 rx_serial = 1'b0; hold_bit();
    for (int i = 0; i < 4; i++) begin rx_serial = rb_bit(8'h49, i); hold_bit(); end
    rx_serial = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1 reset = 1'b0; rx_serial = 1'b1;
    m_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_reset_outputs", {rx_data, rx_valid, cmd_image, cmd_color, frame_err, busy}, '0);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2 * CPB) @(posedge clk); @(negedge clk);
    chk("post_reset_busy", busy, 1'b0);
    chk("post_reset_data", rx_data, 8'h00);
    send_and_check("post_reset_49", 8'h49, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
    send_and_check("par_good_49", 8'h49, 1'b1, 1'b0);
    send_and_check("par_bad_49",  8'h49, 1'b1, 1'b1);
    repeat (5) @(posedge clk); @(negedge clk);
    chk("par_bad_busy", busy, 1'b0);
`endif

    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 3))
        0:       rb = 8'h49;
        1:       rb = 8'h43;
        default: rb = 8'($urandom);
      endcase
      rstop = ($urandom_range(0, 3) != 0);
      send_and_check("rand", rb, rstop, 1'b0);
      repeat ($urandom_range(0, CPB)) @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk); @(negedge clk);
    chk("final_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction
endmodule
